uart_rx_wr: RTL and testbench

UART receive front end that deserialises the rx line and writes each completed byte into the write side of the RX async FIFO. It drives the FIFO write enable and write data, and obeys the FIFO full flag.
All logic runs in the FIFO write clock domain. It provides the oversampling, start-bit qualification, framing checks and overrun reporting for the receive path.

---
 rtl/uart_rx_wr.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_wr.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_wr.sv
// UART receive front end: oversampled deserialiser that writes each good byte into the RX FIFO.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_wr #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  rx,
  input  logic                  full,
  input  logic                  clr_ovr,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_meta_d;
  logic                  rx_s_q, rx_s_d;
  logic                  rx_d_q, rx_d_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]         samp_cnt_q, samp_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  w_en_q, w_en_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;
  logic                  tick;
  logic                  mid;
  logic                  ovr_set;
  logic                  byte_ok;
`ifdef UART_RX_PARITY_EN
  logic                  parity_bit_q, parity_bit_d;
  logic                  parity_err_q, parity_err_d;
  logic                  parity_bad;
`endif

  always_comb begin
    state_d     = state_q;
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    rx_d_d      = rx_s_q;
    tick_cnt_d  = tick_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    w_en_d      = 1'b0;
    wdata_d     = wdata_q;
    frame_err_d = 1'b0;
    ovr_set     = 1'b0;
    tick        = (tick_cnt_q == TICK_LAST);
    mid         = tick && (samp_cnt_q == SAMP_MID);
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = 1'b0;
    parity_bad   = (^shift_q) ^ parity_bit_q;
    byte_ok      = ~parity_bad;
`else
    byte_ok      = 1'b1;
`endif

    // Both counters free-run from the start edge so every mid-bit sample lands OVERSAMPLE ticks apart.
    if (state_q != S_IDLE) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) begin
        samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        samp_cnt_d = '0;
        bit_cnt_d  = '0;
        if (rx_d_q && !rx_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (mid) begin
          state_d   = rx_s_q ? S_IDLE : S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid) begin
          parity_bit_d = rx_s_q;
          state_d      = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (mid) begin
          state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
          parity_err_d = parity_bad;
`endif
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
          end else if (byte_ok) begin
            if (full) begin
              ovr_set = 1'b1;
            end else begin
              w_en_d  = 1'b1;
              wdata_d = shift_q;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new overrun outranks a simultaneous clear so the drop is never lost.
    overrun_d = ovr_set ? 1'b1 : (clr_ovr ? 1'b0 : overrun_q);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_d_q       <= 1'b1;
      tick_cnt_q   <= '0;
      samp_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      w_en_q       <= 1'b0;
      wdata_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_d_q       <= rx_d_d;
      tick_cnt_q   <= tick_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      w_en_q       <= w_en_d;
      wdata_q      <= wdata_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign w_en      = w_en_q;
  assign wdata     = wdata_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_wr.sv
// Scoreboard bench for uart_rx_wr: frames are serialised from a bit-level model and the
// expected FIFO writes / error pulses are queued for a separate monitor to match.
module tb_uart_rx_wr;

   localparam int DW      = 8;
   localparam int CLK_DIV = 4;
   localparam int OVS     = 16;
   localparam int BIT_CYC = CLK_DIV * OVS;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = DW + 2;
`else
   localparam int FRAME_BITS = DW + 1;
`endif
   // Start edge -> two synchroniser flops -> one detect cycle, then half a bit plus the remaining bits.
   localparam int EXP_LATENCY = 3 + BIT_CYC / 2 + FRAME_BITS * BIT_CYC;

   logic          wclk = 1'b0;
   logic          wrst;
   logic          rx;
   logic          full;
   logic          clr_ovr;
   logic          w_en;
   logic [DW-1:0] wdata;
   logic          frame_err;
   logic          overrun;
   logic          busy;
   logic          perrSig;

   typedef struct {
      logic [2:0]    mask;
      logic [DW-1:0] data;
   } ev_t;

   ev_t  evQ[$];
   int   assertCount = 0;
   int   failCount   = 0;
   int   cycleCount  = 0;
   int   startCycle  = 0;
   int   lastLatency = -1;
   logic ovrModel    = 1'b0;
   logic prevWen     = 1'b0;
   logic prevFerr    = 1'b0;

`ifdef UART_RX_PARITY_EN
   logic parity_err;
   assign perrSig = parity_err;
`else
   assign perrSig = 1'b0;
`endif

   uart_rx_wr #(
      .DATA_WIDTH (DW),
      .CLK_DIV    (CLK_DIV),
      .OVERSAMPLE (OVS)
   ) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .rx        (rx),
      .full      (full),
      .clr_ovr   (clr_ovr),
      .w_en      (w_en),
      .wdata     (wdata),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   always #5 wclk = ~wclk;

   // Watchdog so a stuck run still ends with a visible failure.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time budget at cycle %0d", cycleCount);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   // Monitor: any write or error pulse must match the oldest outstanding expectation.
   always @(negedge wclk) begin
      logic [2:0] seen;
      ev_t        expEv;
      cycleCount++;
      seen = {perrSig === 1'b1, frame_err === 1'b1, w_en === 1'b1};
      if (wrst !== 1'b1) begin
         if (seen != 3'b000) begin
            if (evQ.size() == 0) begin
               checkOutput("unexpected_output", {29'd0, seen}, 32'd0);
            end else begin
               expEv = evQ.pop_front();
               checkOutput("event_kind", {29'd0, seen}, {29'd0, expEv.mask});
               if (seen[0]) begin
                  checkOutput("wdata", {24'd0, wdata}, {24'd0, expEv.data});
                  lastLatency = cycleCount - startCycle;
               end
            end
         end
         if (seen[0]) begin
            checkOutput("wen_single_cycle", {31'd0, prevWen}, 32'd0);
            checkOutput("wen_while_full", {31'd0, full}, 32'd0);
         end
         if (seen[1]) checkOutput("ferr_single_cycle", {31'd0, prevFerr}, 32'd0);
      end
      prevWen  = seen[0];
      prevFerr = seen[1];
   end

   // Serialise one frame and record what a correct receiver must do with it.
   task automatic applyStimulus(input logic [DW-1:0] data, input logic stopBit, input logic parityGood,
                                input logic fullVal, input int idleBits);
      ev_t  e;
      logic ferr;
      logic perr;
      logic parBit;
      ferr   = ~stopBit;
      parBit = parityGood ? ^data : ~^data;
`ifdef UART_RX_PARITY_EN
      perr = ~parityGood;
`else
      perr = 1'b0;
      if (!parityGood) $display("[TB] note: parity not compiled in, parity request ignored");
`endif
      e.mask = {perr, ferr, (!ferr && !perr && !fullVal)};
      e.data = data;
      if (e.mask != 3'b000) evQ.push_back(e);
      if (!ferr && !perr && fullVal) ovrModel = 1'b1;

      @(negedge wclk);
      full       = fullVal;
      rx         = 1'b0;
      startCycle = cycleCount;
      repeat (BIT_CYC) @(negedge wclk);
      for (int i = 0; i < DW; i++) begin
         rx = data[i];
         repeat (BIT_CYC) @(negedge wclk);
      end
`ifdef UART_RX_PARITY_EN
      rx = parBit;
      repeat (BIT_CYC) @(negedge wclk);
`else
      if (parBit === 1'bx) $display("[TB] note: unknown parity bit");
`endif
      rx = stopBit;
      repeat (BIT_CYC) @(negedge wclk);
      rx   = 1'b1;
      full = 1'b0;
      repeat (idleBits * BIT_CYC) @(negedge wclk);
   endtask

   task automatic clearOverrun();
      @(negedge wclk);
      clr_ovr = 1'b1;
      @(negedge wclk);
      clr_ovr  = 1'b0;
      ovrModel = 1'b0;
   endtask

   initial begin
      logic          quietBad;
      logic          rnd_stop;
      logic          rnd_par;
      logic          rnd_full;
      logic [DW-1:0] rnd_data;

      rx      = 1'b1;
      full    = 1'b0;
      clr_ovr = 1'b0;
      wrst    = 1'b1;
      repeat (5) @(negedge wclk);
      checkOutput("reset_values", {19'd0, w_en, frame_err, overrun, busy, perrSig, wdata},
                  32'd0);
      wrst = 1'b0;

      quietBad = 1'b0;
      repeat (500) begin
         @(negedge wclk);
         quietBad = quietBad | w_en | frame_err | busy | overrun | perrSig;
      end
      checkOutput("idle_quiet", {31'd0, quietBad}, 32'd0);

      // Nominal bytes, back to back.
      applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 0);
      checkOutput("latency_in_window",
                  {31'd0, (lastLatency >= EXP_LATENCY - 3) && (lastLatency <= EXP_LATENCY + 3)}, 32'd1);
      applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 0);
      applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0, 1);
      checkOutput("drain_nominal", evQ.size(), 32'd0);

      // Glitch shorter than half a bit must be rejected.
      @(negedge wclk);
      rx = 1'b0;
      repeat (10) @(negedge wclk);
      checkOutput("glitch_busy_high", {31'd0, busy}, 32'd1);
      repeat (10) @(negedge wclk);
      rx = 1'b1;
      repeat (100) @(negedge wclk);
      checkOutput("glitch_busy_low", {31'd0, busy}, 32'd0);
      checkOutput("drain_glitch", evQ.size(), 32'd0);

      // Framing error followed by a clean byte.
      applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0, 1);
      checkOutput("ferr_no_overrun", {31'd0, overrun}, {31'd0, ovrModel});
      applyStimulus(8'h55, 1'b1, 1'b1, 1'b0, 1);
      checkOutput("drain_ferr", evQ.size(), 32'd0);

      // Overrun when the FIFO is full, then clear and recover.
      applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 1);
      checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
      clearOverrun();
      checkOutput("overrun_cleared", {31'd0, overrun}, 32'd0);
      applyStimulus(8'h81, 1'b1, 1'b1, 1'b0, 1);
      checkOutput("drain_overrun", evQ.size(), 32'd0);

      // Reset during bit 4 of 0xC3 aborts the frame without a write.
      @(negedge wclk);
      rx = 1'b0;
      repeat (BIT_CYC) @(negedge wclk);
      for (int i = 0; i < 4; i++) begin
         rx = (8'hC3 >> i) & 8'h01;
         repeat (BIT_CYC) @(negedge wclk);
      end
      rx = (8'hC3 >> 4) & 8'h01;
      repeat (30) @(negedge wclk);
      wrst = 1'b1;
      repeat (3) @(negedge wclk);
      rx = 1'b1;
      repeat (5) @(negedge wclk);
      checkOutput("midframe_reset_values", {19'd0, w_en, frame_err, overrun, busy, perrSig, wdata},
                  32'd0);
      wrst     = 1'b0;
      ovrModel = 1'b0;
      repeat (10) @(negedge wclk);
      checkOutput("after_reset_idle", {31'd0, busy}, 32'd0);
      applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0, 1);
      checkOutput("drain_reset", evQ.size(), 32'd0);

`ifdef UART_RX_PARITY_EN
      applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, 1);
      applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("drain_parity", evQ.size(), 32'd0);
`endif

      // Randomised frames with occasional bad stop bits, bad parity, full FIFO and clears.
      for (int n = 0; n < 12; n++) begin
         rnd_data = DW'($urandom);
         rnd_stop = ($urandom_range(0, 3) != 0);
         rnd_par  = ($urandom_range(0, 3) != 0);
         rnd_full = ($urandom_range(0, 3) == 0);
`ifndef UART_RX_PARITY_EN
         rnd_par  = 1'b1;
`endif
         applyStimulus(rnd_data, rnd_stop, rnd_par, rnd_full, 1);
         checkOutput("rand_overrun", {31'd0, overrun}, {31'd0, ovrModel});
         checkOutput("rand_drain", evQ.size(), 32'd0);
         if ($urandom_range(0, 2) == 0) begin
            clearOverrun();
            checkOutput("rand_overrun_clear", {31'd0, overrun}, 32'd0);
         end
      end

      repeat (20) @(negedge wclk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
